reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Holds downstream logic in reset until PLL lock plus a hold time, then releases per-domain resets one by one.
// Define RESET_SEQ_SWRST_EN to add the sw_reset_req input (software-requested resequence).
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   seq_done
`ifdef RESET_SEQ_SWRST_EN
    ,
    input  logic                   sw_reset_req
`endif
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   done_q, done_d;

    logic                   sw_req_s;
    logic                   clear_s;
    logic                   release_s;
    logic [IDX_W-1:0]       rel_idx_s;

`ifdef RESET_SEQ_SWRST_EN
    assign sw_req_s = sw_reset_req;
`else
    assign sw_req_s = 1'b0;
`endif

    // State, counters and output flops; reset_n clears everything without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            dom_q   <= {NUM_DOMAINS{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; PLL loss is checked first so it wins over a software request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        clear_s   = 1'b0;
        release_s = 1'b0;
        rel_idx_s = idx_q;
        case (state_q)
            WAIT_LOCK: begin
                clear_s = 1'b1;
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                if (pll_locked) begin
                    state_d = HOLD;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            HOLD: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    clear_s = 1'b1;
                end else if (sw_req_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (cnt_q == HOLD_LAST) begin
                    release_s = 1'b1;
                    rel_idx_s = {IDX_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    idx_d     = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE, DONE: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    clear_s = 1'b1;
                end else if (sw_req_s) begin
                    state_d = HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    clear_s = 1'b1;
                end else if (state_q == DONE) begin
                    state_d = DONE;
                end else if (cnt_q == GAP_LAST) begin
                    release_s = 1'b1;
                    rel_idx_s = idx_q;
                    cnt_d     = {CNT_W{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                clear_s = 1'b1;
            end
        endcase
    end

    // Output next-values: assertion is simultaneous, release sets exactly one more bit.
    always_comb begin
        dom_d  = dom_q;
        done_d = done_q;
        if (clear_s) begin
            dom_d  = {NUM_DOMAINS{1'b0}};
            done_d = 1'b0;
        end else if (release_s) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (rel_idx_s == IDX_W'(i)) begin
                    dom_d[i] = 1'b1;
                end else begin
                    dom_d[i] = dom_q[i];
                end
            end
            if (state_d == DONE) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            dom_d  = dom_q;
            done_d = done_q;
        end
    end

    assign domain_reset_n = dom_q;
    assign seq_done       = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer at default parameters (4 domains, hold 16, gap 8).
module tb_reset_sequencer;

    logic       clock;
    logic       reset_n;
    logic       pll_locked;
    logic [3:0] domain_reset_n;
    logic       seq_done;
    logic       sw_reset_req;
    int         checks;
    int         errors;

    reset_sequencer #(
        .NUM_DOMAINS(4),
        .HOLD_CYCLES(16),
        .GAP_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .domain_reset_n(domain_reset_n),
        .seq_done      (seq_done)
`ifdef RESET_SEQ_SWRST_EN
        ,
        .sw_reset_req  (sw_reset_req)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {seq_done, domain_reset_n} k edges after the lock edge E0 (k = 0 is E0 itself).
    function automatic logic [4:0] exp_out(input int k);
        logic [3:0] d;
        d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (k >= 16 + 8 * i) d[i] = 1'b1;
        end
        return {(k >= 40) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        sw_reset_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        #3;
        checks++;
        if ({seq_done, domain_reset_n} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", {seq_done, domain_reset_n}, 5'b00000);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_held c=%0d got=%b want=%b", c, {seq_done, domain_reset_n}, 5'b00000);
            end
        end
    endtask

    task automatic test_normal();
        apply_reset();
        pll_locked = 1'b1;
        reset_n    = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL normal k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask

    task automatic test_late_lock();
        apply_reset();
        reset_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== 5'b00000) begin
                errors++;
                $display("FAIL late_lock_low c=%0d got=%b want=%b", c, {seq_done, domain_reset_n}, 5'b00000);
            end
        end
        pll_locked = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL late_lock k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask

    task automatic test_hold_drop();
        apply_reset();
        pll_locked = 1'b1;
        reset_n    = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        pll_locked = 1'b0;
        tick();
        checks++;
        if ({seq_done, domain_reset_n} !== 5'b00000) begin
            errors++;
            $display("FAIL hold_drop got=%b want=%b", {seq_done, domain_reset_n}, 5'b00000);
        end
        pll_locked = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL hold_relock k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask

    task automatic test_done_drop();
        pll_locked = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== 5'b00000) begin
                errors++;
                $display("FAIL done_drop c=%0d got=%b want=%b", c, {seq_done, domain_reset_n}, 5'b00000);
            end
        end
        pll_locked = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL done_relock k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask

    task automatic test_async_mid();
        apply_reset();
        pll_locked = 1'b1;
        reset_n    = 1'b1;
        for (int k = 0; k <= 28; k++) tick();
        checks++;
        if ({seq_done, domain_reset_n} !== 5'b00011) begin
            errors++;
            $display("FAIL async_pre got=%b want=%b", {seq_done, domain_reset_n}, 5'b00011);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({seq_done, domain_reset_n} !== 5'b00000) begin
            errors++;
            $display("FAIL async_mid got=%b want=%b", {seq_done, domain_reset_n}, 5'b00000);
        end
        reset_n = 1'b1;
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL async_restart k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask

`ifdef RESET_SEQ_SWRST_EN
    task automatic test_sw_reset();
        sw_reset_req = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            sw_reset_req = 1'b0;
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL sw_done k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        tick();
        sw_reset_req = 1'b0;
        pll_locked   = 1'b1;
        checks++;
        if ({seq_done, domain_reset_n} !== 5'b00000) begin
            errors++;
            $display("FAIL sw_pll_loss got=%b want=%b", {seq_done, domain_reset_n}, 5'b00000);
        end
        for (int k = 0; k <= 10; k++) tick();
        sw_reset_req = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            sw_reset_req = 1'b0;
            checks++;
            if ({seq_done, domain_reset_n} !== exp_out(k)) begin
                errors++;
                $display("FAIL sw_hold k=%0d got=%b want=%b", k, {seq_done, domain_reset_n}, exp_out(k));
            end
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        test_reset();
        test_normal();
        test_late_lock();
        test_hold_drop();
        test_done_drop();
        test_async_mid();
`ifdef RESET_SEQ_SWRST_EN
        test_sw_reset();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
